ram_sp_rr_arbiter: RTL
======================

Name: ram_sp_rr_arbiter

Overview:
Two-requester round-robin arbiter that shares one single-port RAM (ram_sp_async_read, 16x8, synchronous write, asynchronous read) between requesters A and B. Each granted request is one read or write access. The block contains the RAM instance and returns read data per requester with a valid pulse. It sits between two bus masters (e.g. a loader and a consumer) and the shared scratch RAM.

Parameters:
ADDR_W, 4, RAM address width (depth 2**ADDR_W)
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_a  in  1  requester A access request, level, held until gnt_a
we_a  in  1  A: 1 = write, 0 = read; stable while req_a high
addr_a  in  ADDR_W  A access address
wdata_a  in  DATA_W  A write data
gnt_a  out  1  A command accepted (one-cycle pulse)
rdata_a  out  DATA_W  A read data, valid when rvalid_a
rvalid_a  out  1  A read data valid (one-cycle pulse)
req_b, we_b, addr_b, wdata_b, gnt_b, rdata_b, rvalid_b: same as A, for requester B
busy  out  1  high while in ACCESS

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
- Reset values: state=IDLE, last_gnt=B, gnt_a/gnt_b=0, rvalid_a/rvalid_b=0, rdata_a/rdata_b=0, busy=0, RAM write_en=0.
- FSM states: IDLE, ACCESS.
- IDLE, at a rising edge:
  - If any req is high, latch winner's we/addr/wdata into cmd_we/cmd_addr/cmd_wdata and cmd_owner.
  - Set gnt_<owner>=1 and last_gnt=owner; go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_gnt. First tie after reset goes to A.
- ACCESS, for exactly one cycle:
  - RAM address = cmd_addr, data_in = cmd_wdata, write_en = cmd_we. write_en is combinational from state==ACCESS && cmd_we.
  - At the closing edge: a write commits to the RAM; a read captures RAM data_out into rdata_<owner> and pulses rvalid_<owner> for the next cycle.
  - gnt clears at that edge and the FSM returns to IDLE.
  - Requests are not sampled in ACCESS.
- Latency, request sampled at edge N:
  - gnt high in cycle N..N+1.
  - Write lands at edge N+1.
  - rvalid high in cycle N+1..N+2 with rdata stable.
  - Throughput: at most one access per 2 cycles.
- Handshake: a requester must drop req, or present its next command, in the cycle gnt is high. A req still high at the next IDLE edge is a new request.
- rdata_x holds its last value until the next read by the same requester.
- RAM ports in IDLE: write_en=0; address and data_in hold cmd_* values.
- Read-after-write to the same address by either requester returns the new data (write commits before the next IDLE arbitration).
- Address wrap: none. Address is used as given; all 2**ADDR_W locations are valid.
- Async reset mid-ACCESS:
  - write_en drops immediately, so an in-flight write does not commit.
  - No rvalid is produced; the FSM is in IDLE on release.
  - RAM contents are not cleared.
- Simultaneous gnt_a and gnt_b, or rvalid_a and rvalid_b, never occur.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, ACCESS=1'b1), owner encoding (OWN_A=1'b0, OWN_B=1'b1), default ADDR_W/DATA_W.
- One sub-module: ram_sp_async_read, the existing RAM, instantiated as-is with clk, data_in, address, write_en, data_out.
- Arbitration and FSM stay flat in ram_sp_rr_arbiter.

Test Plan:
- Reset, then A writes 0xA5 to addr 3, then A reads addr 3 -> gnt_a one cycle after each sampled req; rvalid_a pulse with rdata_a=0xA5; busy toggles 1,0.
- req_a and req_b high together from reset, A reads addr 1, B reads addr 2 -> gnt_a first, gnt_b two cycles later; both held continuously -> strict alternation A,B,A,B.
- B writes 0x3C to addr 15, then A reads addr 15 -> rdata_a=0x3C, rvalid_b never asserted.
- Loop over all 16 addresses: write $random, read back, compare -> 16/16 match; rdata_b unchanged during A-only traffic.
- Assert rst_n low mid-ACCESS of A writing 0xFF to addr 5 (previously 0x11), release, read addr 5 -> 0x11; gnt/rvalid low during and right after reset.
- req_a held high through gnt_a with a new command (read addr 0) -> treated as a second request, granted at the next IDLE edge; no access lost or duplicated.

Source files
------------

// File: rtl/ram_sp_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_rr_arbiter_pkg
// Brief    : Shared encodings and default widths for the RR RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_sp_rr_arbiter_pkg;

    localparam int c_addr_w = 4;
    localparam int c_data_w = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/ram_sp_async_read.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_async_read
// Brief    : Single-port RAM, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sp_async_read
    import ram_sp_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_en,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (write_en) begin
            r_mem[address] <= data_in;
        end
    end

    assign data_out = r_mem[address];

endmodule
`default_nettype wire

// File: rtl/ram_sp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_rr_arbiter
// Brief    : Two-requester round-robin arbiter in front of a shared SP RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sp_rr_arbiter
    import ram_sp_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_last_gnt;
    owner_t              r_cmd_owner;
    owner_t              w_winner;
    logic                w_any_req;
    logic                r_cmd_we;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_wdata;
    logic                w_write_en;
    logic [DATA_W-1:0]   w_ram_dout;

    assign w_any_req = req_a | req_b;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        w_winner = OWN_A;
        if (req_a && req_b) begin
            w_winner = (r_last_gnt == OWN_A) ? OWN_B : OWN_A;
        end else if (req_b) begin
            w_winner = OWN_B;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt  <= OWN_B;
            r_cmd_owner <= OWN_A;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            if (r_state == ST_IDLE && w_any_req) begin
                r_cmd_owner <= w_winner;
                r_last_gnt  <= w_winner;
                r_cmd_we    <= (w_winner == OWN_A) ? we_a    : we_b;
                r_cmd_addr  <= (w_winner == OWN_A) ? addr_a  : addr_b;
                r_cmd_wdata <= (w_winner == OWN_A) ? wdata_a : wdata_b;
                gnt_a       <= (w_winner == OWN_A);
                gnt_b       <= (w_winner == OWN_B);
            end
        end
    end

    // Read data is captured at the edge that closes ACCESS; rdata holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a  <= '0;
            rdata_b  <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            if (r_state == ST_ACCESS && !r_cmd_we) begin
                if (r_cmd_owner == OWN_A) begin
                    rdata_a  <= w_ram_dout;
                    rvalid_a <= 1'b1;
                end else begin
                    rdata_b  <= w_ram_dout;
                    rvalid_b <= 1'b1;
                end
            end
        end
    end

    // Combinational so an async reset during ACCESS kills an in-flight write.
    assign w_write_en = (r_state == ST_ACCESS) && r_cmd_we;
    assign busy       = (r_state == ST_ACCESS);

    ram_sp_async_read #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk      (clk),
        .data_in  (r_cmd_wdata),
        .address  (r_cmd_addr),
        .write_en (w_write_en),
        .data_out (w_ram_dout)
    );

endmodule
`default_nettype wire
